// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed Booth multiplier / restoring divider with fixed 33-cycle latency
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);
    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;
    state_t state, state_nx;
    logic [2*WIDTH:0] p, mul_nx, div_nx;
    logic [WIDTH-1:0] m, abs_a, abs_b, up, rs, q, quo;
    logic [WIDTH:0]   sum, diff;
    logic [5:0]       cnt;
    logic             sgn, dz, ovf, last, busy;
    always_ff @(posedge clock or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_nx;
    assign busy = state == MULT || state == DIV;
    assign last = cnt == 6'(ITER);
    always_comb begin
        state_nx = ctrl_MULT ? MULT : ctrl_DIV ? DIV : busy ? (last ? DONE : state) : IDLE;
    end
    assign data_resultRDY = state == DONE;
    assign abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    // Booth step: 33-bit sum keeps the sign when subtracting the most negative multiplicand
    assign up     = p[2*WIDTH:WIDTH+1];
    assign sum    = p[1:0] == 2'b01 ? {up[WIDTH-1], up} + {m[WIDTH-1], m} :
                    p[1:0] == 2'b10 ? {up[WIDTH-1], up} - {m[WIDTH-1], m} : {up[WIDTH-1], up};
    assign mul_nx = {sum, p[WIDTH:1]};
    // Restoring step on {R, Q} held in p[2W-1:0]
    assign rs     = p[2*WIDTH-2:WIDTH-1];
    assign diff   = {1'b0, rs} - {1'b0, m};
    assign div_nx = {1'b0, diff[WIDTH] ? rs : diff[WIDTH-1:0], p[WIDTH-2:0], ~diff[WIDTH]};
    assign q      = p[WIDTH-1:0];
    assign quo    = sgn ? -q : q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            p              <= '0;
            m              <= '0;
            cnt            <= '0;
            sgn            <= 1'b0;
            dz             <= 1'b0;
            ovf            <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (ctrl_MULT) begin
            p   <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
            m   <= data_operandA;
            cnt <= '0;
        end else if (ctrl_DIV) begin
            p   <= {{(WIDTH+1){1'b0}}, abs_a};
            m   <= abs_b;
            cnt <= '0;
            sgn <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            dz  <= data_operandB == '0;
            ovf <= data_operandA == {1'b1, {(WIDTH-1){1'b0}}} && data_operandB == '1;
        end else if (busy && !last) begin
            p   <= state == MULT ? mul_nx : div_nx;
            cnt <= cnt + 6'd1;
        end else if (state == MULT) begin
            data_result    <= p[WIDTH:1];
            data_exception <= p[2*WIDTH:WIDTH+1] != {WIDTH{p[WIDTH]}};
        end else if (state == DIV) begin
            data_result    <= dz ? '0 : quo;
            data_exception <= dz | ovf;
        end
    end
endmodule
